sensor_conditioner: RTL and testbench

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/sensor_conditioner.sv | 147 ++++++++++++++
 tb/tb_sensor_conditioner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner.sv
`default_nettype none
// ------------------------------------------------------------------------
// sensor_conditioner: 2-bit humidity sensor sync/debounce and latched alarm FSM
// Rev 1.0
// ------------------------------------------------------------------------
module sensor_conditioner #(
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int ALARM_HOLD      = 4
) (
   input  logic       clk_2,
   input  logic       reset,
   input  logic [1:0] sensor_raw,
   input  logic       ack,
   output logic [1:0] status,
   output logic       status_valid,
   output logic       alarm,
   output logic [7:0] alarm_count,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,
      ST_WARN   = 2'd1,
      ST_ALARM  = 2'd2,
      ST_ACKED  = 2'd3
   } state_t;

   localparam logic [7:0] C_DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] C_HOLD_LAST = 8'(ALARM_HOLD - 1);

   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic [1:0] r_stable;
   logic [1:0] w_take;
   logic       r_valid;

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         r_sync1 <= 2'b00;
         r_sync2 <= 2'b00;
      end else begin
         r_sync1 <= sensor_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Each bit flips only after DEBOUNCE_CYCLES consecutive mismatching edges.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_debounce
         logic [7:0] r_cnt;
         logic       w_mis;

         assign w_mis      = r_sync2[gi] ^ r_stable[gi];
         assign w_take[gi] = w_mis && (r_cnt == C_DEB_LAST);

         always_ff @(posedge clk_2 or posedge reset) begin
            if (reset) begin
               r_cnt <= 8'd0;
            end else if (!w_mis || w_take[gi]) begin
               r_cnt <= 8'd0;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         r_stable <= 2'b00;
         r_valid  <= 1'b0;
      end else begin
         r_stable <= (r_stable & ~w_take) | (r_sync2 & w_take);
         r_valid  <= |w_take;
      end
   end

   state_t     r_state;
   state_t     w_state_nxt;
   state_t     w_level_state;
   logic [7:0] r_hold;
   logic [7:0] w_hold_nxt;
   logic [7:0] r_alarm_cnt;
   logic [7:0] w_alarm_cnt_nxt;
   logic       r_alarm;
   logic       w_both;

   assign w_both        = &r_stable;
   assign w_level_state = (|r_stable) ? ST_WARN : ST_NORMAL;

   always_comb begin
      w_state_nxt     = ST_NORMAL;
      w_hold_nxt      = 8'd0;
      w_alarm_cnt_nxt = r_alarm_cnt;
      case (r_state)
         ST_NORMAL, ST_WARN: begin
            if (!w_both) begin
               w_state_nxt = w_level_state;
            end else if (r_hold == C_HOLD_LAST) begin
               w_state_nxt = ST_ALARM;
               if (r_alarm_cnt != 8'hFF) begin
                  w_alarm_cnt_nxt = r_alarm_cnt + 8'd1;
               end
            end else begin
               w_state_nxt = r_state;
               w_hold_nxt  = r_hold + 8'd1;
            end
         end
         ST_ALARM: begin
            if (ack) begin
               w_state_nxt = w_both ? ST_ACKED : w_level_state;
            end else begin
               w_state_nxt = ST_ALARM;
            end
         end
         ST_ACKED: begin
            w_state_nxt = w_both ? ST_ACKED : w_level_state;
         end
         default: begin
            w_state_nxt = ST_NORMAL;
         end
      endcase
   end

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         r_state     <= ST_NORMAL;
         r_hold      <= 8'd0;
         r_alarm_cnt <= 8'd0;
         r_alarm     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hold      <= w_hold_nxt;
         r_alarm_cnt <= w_alarm_cnt_nxt;
         r_alarm     <= (w_state_nxt == ST_ALARM);
      end
   end

   assign status       = r_stable;
   assign status_valid = r_valid;
   assign alarm        = r_alarm;
   assign alarm_count  = r_alarm_cnt;
   assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_sensor_conditioner: directed + random checks against a behavioural model
// Rev 1.0
// ------------------------------------------------------------------------
module tb_sensor_conditioner;

   localparam int DEB  = 3;
   localparam int HOLD = 4;

   logic       clk_2 = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] sensor_raw = 2'b00;
   logic       ack = 1'b0;
   logic [1:0] status;
   logic       status_valid;
   logic       alarm;
   logic [7:0] alarm_count;
   logic [1:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_2 = ~clk_2;

   sensor_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .ALARM_HOLD     (HOLD)
   ) u_dut (
      .clk_2       (clk_2),
      .reset       (reset),
      .sensor_raw  (sensor_raw),
      .ack         (ack),
      .status      (status),
      .status_valid(status_valid),
      .alarm       (alarm),
      .alarm_count (alarm_count),
      .state       (state)
   );

   // Reference: raw input travels two samples, then a bit is accepted once it
   // has disagreed with the accepted level on DEB consecutive edges.
   logic [1:0] m_s1, m_s2, m_stable, m_nst;
   logic       m_valid;
   int         m_run [2];
   int         m_state, m_hold, m_cnt;

   function automatic int level_of(input logic [1:0] s);
      return (s == 2'b00) ? 0 : 1;
   endfunction

   always @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         m_s1 = 2'b00; m_s2 = 2'b00; m_stable = 2'b00; m_valid = 1'b0;
         m_run[0] = 0; m_run[1] = 0;
         m_state = 0; m_hold = 0; m_cnt = 0;
      end else begin
         case (m_state)
            0, 1: begin
               if (m_stable == 2'b11) begin
                  m_hold++;
                  if (m_hold == HOLD) begin
                     m_state = 2;
                     m_hold  = 0;
                     if (m_cnt < 255) m_cnt++;
                  end
               end else begin
                  m_hold  = 0;
                  m_state = level_of(m_stable);
               end
            end
            2: if (ack) m_state = (m_stable == 2'b11) ? 3 : level_of(m_stable);
            default: if (m_stable != 2'b11) m_state = level_of(m_stable);
         endcase
         m_nst = m_stable;
         for (int i = 0; i < 2; i++) begin
            if (m_s2[i] != m_stable[i]) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  m_nst[i] = m_s2[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_valid  = (m_nst != m_stable);
         m_stable = m_nst;
         m_s2     = m_s1;
         m_s1     = sensor_raw;
      end
   end

   always @(negedge clk_2) begin
      n_checks++;
      if (status !== m_stable || status_valid !== m_valid || alarm !== (m_state == 2) ||
          alarm_count !== 8'(m_cnt) || state !== 2'(m_state)) begin
         n_fail++;
         $display("FAIL model_compare t=%0t got status=%b valid=%b alarm=%b cnt=%0d state=%0d expected status=%b valid=%b alarm=%b cnt=%0d state=%0d",
                  $time, status, status_valid, alarm, alarm_count, state,
                  m_stable, m_valid, (m_state == 2), m_cnt, m_state);
      end
   end

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_2);
      #1;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      step(1);
      ack = 1'b0;
   endtask

   initial begin
      int v;
      step(3);
      check("reset_state", state, 0);
      check("reset_count", alarm_count, 0);
      check("reset_status", status, 0);

      // single sensor goes dry
      reset = 1'b0;
      sensor_raw = 2'b01;
      step(4);
      check("deb_not_yet", status, 0);
      step(1);
      check("deb_status", status, 1);
      check("deb_valid", status_valid, 1);
      step(1);
      check("valid_drop", status_valid, 0);
      check("warn_state", state, 1);
      check("warn_alarm", alarm, 0);

      // short glitch is rejected
      sensor_raw = 2'b00;
      step(8);
      check("back_normal", status, 0);
      sensor_raw = 2'b01;
      step(2);
      sensor_raw = 2'b00;
      v = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (status_valid) v++;
      end
      check("glitch_status", status, 0);
      check("glitch_valid_pulses", v, 0);

      // both sensors dry -> alarm after hold
      sensor_raw = 2'b11;
      step(5);
      check("both_status", status, 3);
      step(3);
      check("alarm_not_yet", alarm, 0);
      step(1);
      check("alarm_state", state, 2);
      check("alarm_out", alarm, 1);
      check("alarm_count1", alarm_count, 1);
      sensor_raw = 2'b00;
      step(10);
      check("alarm_latched", alarm, 1);

      // ack -> ACKED, then WARN, then re-alarm
      sensor_raw = 2'b11;
      step(10);
      pulse_ack();
      check("acked_state", state, 3);
      check("acked_alarm", alarm, 0);
      sensor_raw = 2'b10;
      step(6);
      check("acked_to_warn", state, 1);
      sensor_raw = 2'b11;
      step(9);
      check("realarm_state", state, 2);
      check("alarm_count2", alarm_count, 2);

      // ack on the alarm-entry edge is ignored
      pulse_ack();
      sensor_raw = 2'b00;
      step(7);
      sensor_raw = 2'b11;
      step(8);
      check("pre_entry_state", state, 0);
      pulse_ack();
      check("entry_ack_ignored", state, 2);
      step(1);
      check("entry_ack_held", state, 2);
      check("alarm_count3", alarm_count, 3);

      // saturate the entry counter
      for (int i = 0; i < 253; i++) begin
         pulse_ack();
         sensor_raw = 2'b00;
         step(7);
         sensor_raw = 2'b11;
         step(9);
      end
      check("count_saturated", alarm_count, 255);
      check("sat_alarm", alarm, 1);

      // ack in NORMAL has no effect
      pulse_ack();
      sensor_raw = 2'b00;
      step(7);
      check("normal_state", state, 0);
      pulse_ack();
      check("normal_ack_ignored", state, 0);

      // asynchronous reset while in ALARM
      sensor_raw = 2'b11;
      step(9);
      check("pre_reset_alarm", alarm, 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_alarm", alarm, 0);
      check("async_rst_state", state, 0);
      check("async_rst_count", alarm_count, 0);
      check("async_rst_status", status, 0);
      step(1);
      reset = 1'b0;

      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 11) == 0) sensor_raw = 2'($urandom_range(0, 3));
         ack = ($urandom_range(0, 9) == 0);
         reset = ($urandom_range(0, 599) == 0);
         step(1);
      end
      reset = 1'b0;
      ack = 1'b0;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
